predecode_stage_controller: RTL
===============================

# predecode_stage_controller

Sequencing controller for the pre-decode stage. It generates the stage's stall and clear controls from decode-stage back-pressure, pipeline flush requests and serialization requests. Serialization requests come from CSR, fence and system instructions that need an empty front end. The block sits in the controller beside the fetch/pre-decode pipeline registers. It also provides a drain watchdog and a stall-cycle performance counter.

## Interface
- FLUSH_CYCLES, 2, cycles spent in FLUSH after the request cycle; legal range 1..15.
- DRAIN_TIMEOUT, 200, DRAIN cycles before the watchdog fires; legal range 1..255.
- CNT_WIDTH, 32, width of the stall-cycle counter.
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Low = reset.
- idStall  in  1  back-pressure from the decode stage.
- flushReq  in  1  single-cycle flush pulse from recovery.
- serializeReq  in  1  level request to drain the front end and hold it.
- pdEmpty  in  1  pre-decode pipeline register holds no valid entry.
- backendEmpty  in  1  decode and later front-end stages are empty.
- perfClear  in  1  synchronous clear of stallCycles.
- pdStall  out  1  stall for the pre-decode stage.
- pdClear  out  1  clear for the pre-decode stage.
- fetchStall  out  1  blocks fetch from writing new instructions.
- serializeAck  out  1  front end is drained and held.
- drainTimeout  out  1  one-cycle pulse when the watchdog fires.
- state  out  2  current state: RUN=0, FLUSH=1, DRAIN=2, HOLD=3.
- stallCycles  out  CNT_WIDTH  saturating count of cycles with pdStall=1.

## Operation
- Reset (rst low, asynchronous) forces state=RUN, the flush counter to 0, the watchdog counter to 0, stallCycles=0 and drainTimeout=0. All other outputs then decode to 0.

State transitions, evaluated each cycle, first match wins:
- flushReq=1 in any state → FLUSH, flush counter := FLUSH_CYCLES-1, watchdog := 0.
- FLUSH with counter≠0 → FLUSH, counter decrements.
- FLUSH with counter=0 → DRAIN if serializeReq=1, else RUN.
- RUN with serializeReq=1 → DRAIN, watchdog := 0.
- DRAIN with pdEmpty=1 and backendEmpty=1 → HOLD.
- DRAIN otherwise → stays in DRAIN, watchdog increments and saturates at DRAIN_TIMEOUT.
- HOLD with serializeReq=0 → RUN.

Output decode (combinational from the registered state plus the listed inputs):
- pdClear = flushReq OR (state==FLUSH).
- pdStall = NOT pdClear AND ((state==HOLD) OR idStall).
- fetchStall = flushReq OR (state≠RUN) OR (state==RUN AND serializeReq).
- serializeAck = (state==HOLD) AND NOT flushReq.

Watchdog and counter:
- drainTimeout is a registered pulse, high for exactly one cycle. It fires in the cycle after the watchdog reaches DRAIN_TIMEOUT-1 while the block stays in DRAIN. It fires at most once per DRAIN visit. The block stays in DRAIN after it fires; it does not recover on its own.
- stallCycles increments in each cycle where pdStall=1. It saturates at all-ones.
- perfClear forces stallCycles to 0 and takes priority over the increment.

## Timing
- Flush: pdClear is high in the flushReq cycle and in the next FLUSH_CYCLES cycles, for FLUSH_CYCLES+1 cycles in total. pdStall is low throughout. fetchStall is high over the same cycles.
- flushReq arriving while in FLUSH restarts the counter, extending the clear window.
- idStall reaches pdStall in the same cycle; there is no added latency.
- Serialize with an already empty front end:
  - cycle 0: serializeReq rises, fetchStall=1.
  - cycle 1: block is in DRAIN.
  - cycle 2: block is in HOLD, serializeAck=1.
- Release: serializeReq falls in the HOLD cycle; state=RUN the next cycle, where serializeAck=0 and fetchStall=0.
- Flush during HOLD:
  - serializeAck drops in the same cycle.
  - After FLUSH, the block returns to DRAIN if serializeReq is still high.
  - serializeAck must not re-assert until the front end has re-drained.
- Simultaneous flushReq and serializeReq rising in RUN: flush wins; DRAIN follows FLUSH.
- Reset asserted mid-FLUSH or mid-HOLD: outputs go low immediately, without waiting for a clock edge.

## Test plan
- Reset: hold rst low with random inputs → state=0 and pdStall=pdClear=fetchStall=serializeAck=drainTimeout=0. stallCycles=0.
- Flush (FLUSH_CYCLES=2): pulse flushReq at cycle 10 → pdClear=1 and fetchStall=1 for cycles 10–12. state=1 for cycles 11–12 and 0 at cycle 13. pdStall=0 throughout, including with idStall=1.
- Serialize: raise serializeReq with pdEmpty=0 and backendEmpty=1. Raise pdEmpty at cycle 5 → HOLD at cycle 6 with serializeAck=1 and pdStall=1. Drop serializeReq at cycle 9 → RUN at cycle 10.
- Flush during HOLD: pulse flushReq while in HOLD with serializeReq held high → serializeAck=0 that cycle, then FLUSH for 2 cycles. The block then goes through DRAIN and is back in HOLD 2 cycles later with both empties high.
- Watchdog (DRAIN_TIMEOUT=4): enter DRAIN with pdEmpty=0 → drainTimeout pulses for one cycle, 4 cycles after entering DRAIN. The pulse occurs exactly once and the block stays in DRAIN.
- Counter: idStall=1 for 7 cycles → stallCycles=7. Then perfClear=1 together with idStall=1 → 0. With CNT_WIDTH=4, 20 stall cycles → stallCycles=15.

Source files
------------

// File: rtl/predecode_stage_controller.sv
// predecode_stage_controller
// Sequencing controller for the pre-decode stage. Turns decode back-pressure,
// flush pulses and serialization requests into the stage stall/clear
// controls. Also provides a drain watchdog and a stall-cycle counter.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   idStall             decode-stage back-pressure
//   flushReq            single-cycle flush pulse
//   serializeReq        level request to drain and hold the front end
//   pdEmpty             pre-decode register holds no valid entry
//   backendEmpty        decode and later front-end stages are empty
//   perfClear           synchronous clear of stallCycles
//   pdStall, pdClear    pre-decode stage controls
//   fetchStall          blocks fetch from writing new instructions
//   serializeAck        front end is drained and held
//   drainTimeout        one-cycle watchdog pulse
//   state               RUN=0, FLUSH=1, DRAIN=2, HOLD=3
//   stallCycles         saturating count of pdStall cycles
module predecode_stage_controller #(
    parameter int FLUSH_CYCLES  = 2,
    parameter int DRAIN_TIMEOUT = 200,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 idStall,
    input  logic                 flushReq,
    input  logic                 serializeReq,
    input  logic                 pdEmpty,
    input  logic                 backendEmpty,
    input  logic                 perfClear,
    output logic                 pdStall,
    output logic                 pdClear,
    output logic                 fetchStall,
    output logic                 serializeAck,
    output logic                 drainTimeout,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stallCycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WDOG_MAX   = 8'(DRAIN_TIMEOUT);
    localparam logic [7:0] WDOG_FIRE  = 8'(DRAIN_TIMEOUT - 1);

    state_t     cur;
    logic [3:0] flush_cnt;
    logic [7:0] wdog;
    logic       timeout_q;
    logic       drained;
    logic       drain_stay;
    logic       clear_raw;

    assign drained    = pdEmpty & backendEmpty;
    assign drain_stay = (cur == DRAIN) && !flushReq && !drained;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur       <= RUN;
            flush_cnt <= '0;
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            // The watchdog saturates at DRAIN_TIMEOUT, so it passes through
            // the fire value only once per DRAIN visit.
            timeout_q <= drain_stay && (wdog == WDOG_FIRE);
            if (flushReq) begin
                cur       <= FLUSH;
                flush_cnt <= FLUSH_LOAD;
                wdog      <= '0;
            end else begin
                case (cur)
                    RUN: begin
                        if (serializeReq) begin
                            cur  <= DRAIN;
                            wdog <= '0;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt != 4'd0)
                            flush_cnt <= flush_cnt - 4'd1;
                        else
                            cur <= serializeReq ? DRAIN : RUN;
                    end
                    DRAIN: begin
                        if (drained)
                            cur <= HOLD;
                        else if (wdog != WDOG_MAX)
                            wdog <= wdog + 8'd1;
                    end
                    HOLD: begin
                        if (!serializeReq)
                            cur <= RUN;
                    end
                    default: cur <= RUN;
                endcase
            end
        end
    end

    // Decoded outputs are gated by rst so they drop the moment reset
    // asserts, even though flushReq/idStall feed them combinationally.
    assign clear_raw    = flushReq || (cur == FLUSH);
    assign pdClear      = rst && clear_raw;
    assign pdStall      = rst && !clear_raw && ((cur == HOLD) || idStall);
    assign fetchStall   = rst && (flushReq || (cur != RUN) || serializeReq);
    assign serializeAck = rst && (cur == HOLD) && !flushReq;
    assign drainTimeout = timeout_q;
    assign state        = cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stallCycles <= '0;
        else if (perfClear)
            stallCycles <= '0;
        else if (pdStall && (stallCycles != {CNT_WIDTH{1'b1}}))
            stallCycles <= stallCycles + 1'b1;
    end

endmodule
